// File: rtl/gnr_attractor_ctrl.sv
// gnr_attractor_ctrl: Floyd tortoise/hare sequencer that locates the attractor of a GNR node network
module gnr_attractor_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] gads_s0,
    input  logic [N_NODES-1:0] gads_s1,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               timeout,
    output logic [CNT_W-1:0]   meet_steps,
    output logic [CNT_W-1:0]   period,
    output logic [N_NODES-1:0] attractor
);
    typedef enum logic [2:0] {IDLE, INIT, M_STEP, M_CMP, P_STEP, P_CMP, FIN} state_t;
    localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_STEPS);
    state_t state_q, state_d;
    logic [CNT_W-1:0] k_q, k_d, p_q, p_d, meet_q, meet_d, period_q, period_d;
    logic [N_NODES-1:0] init_q, init_d, attr_q, attr_d;
    logic found_q, found_d, timeout_q, timeout_d;
    logic reset_nos_q, reset_nos_d, start_s0_q, start_s0_d, start_s1_q, start_s1_d;
    logic busy_q, busy_d, done_q, done_d;
    // next state, counters and results; pulse outputs are decoded from the next state so they register with it
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        p_d       = p_q;
        meet_d    = meet_q;
        period_d  = period_q;
        init_d    = init_q;
        attr_d    = attr_q;
        found_d   = found_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: if (start) begin
                init_d    = init_vec;
                found_d   = 1'b0;
                timeout_d = 1'b0;
                meet_d    = '0;
                period_d  = '0;
                attr_d    = '0;
                k_d       = '0;
                p_d       = '0;
                state_d   = INIT;
            end
            INIT: state_d = M_STEP;
            M_STEP: begin
                k_d     = k_q + 1'b1;
                state_d = M_CMP;
            end
            M_CMP: begin
                // odd k leaves the tortoise a half step behind, so only even k can be a genuine meeting
                if (!k_q[0] && gads_s0 == gads_s1) begin
                    attr_d  = gads_s0;
                    meet_d  = k_q;
                    p_d     = '0;
                    state_d = P_STEP;
                end else if (k_q == MAX) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    state_d = M_STEP;
                end
            end
            P_STEP: begin
                p_d     = p_q + 1'b1;
                state_d = P_CMP;
            end
            P_CMP: begin
                if (gads_s1 == attr_q) begin
                    period_d = p_q;
                    found_d  = 1'b1;
                    state_d  = FIN;
                end else if (p_q == MAX) begin
                    timeout_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    state_d = P_STEP;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        reset_nos_d = state_d == INIT;
        start_s0_d  = state_d == M_STEP;
        start_s1_d  = state_d == M_STEP || state_d == P_STEP;
        done_d      = state_d == FIN;
        busy_d      = state_d != IDLE && state_d != FIN;
    end
    // state and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            p_q         <= '0;
            meet_q      <= '0;
            period_q    <= '0;
            init_q      <= '0;
            attr_q      <= '0;
            found_q     <= 1'b0;
            timeout_q   <= 1'b0;
            reset_nos_q <= 1'b0;
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            p_q         <= p_d;
            meet_q      <= meet_d;
            period_q    <= period_d;
            init_q      <= init_d;
            attr_q      <= attr_d;
            found_q     <= found_d;
            timeout_q   <= timeout_d;
            reset_nos_q <= reset_nos_d;
            start_s0_q  <= start_s0_d;
            start_s1_q  <= start_s1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
    assign reset_nos  = reset_nos_q;
    assign init_state = init_q;
    assign start_s0   = start_s0_q;
    assign start_s1   = start_s1_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign found      = found_q;
    assign timeout    = timeout_q;
    assign meet_steps = meet_q;
    assign period     = period_q;
    assign attractor  = attr_q;
endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb_gnr_attractor_ctrl: node-network environment plus orbit-based reference model for gnr_attractor_ctrl
module tb_gnr_attractor_ctrl;
    localparam int N = 8;
    localparam int W = 16;
    localparam int MAXS = 200;
    logic clk = 0, rst = 1, start = 0;
    logic [N-1:0] init_vec = '0, gads_s0, gads_s1, init_state, attractor;
    logic reset_nos, start_s0, start_s1, busy, done, found, timeout;
    logic [W-1:0] meet_steps, period;
    int vectors = 0, errors = 0;
    int mode = 0;
    logic [N-1:0] tab [0:255];
    logic [N-1:0] s0, s1;
    logic flag;
    int n_rst, n_s0, n_s1, n_busy, n_done;
    logic prev_rn = 0, prev_done = 0;
    bit e_found, e_to;
    int e_k, e_p;
    logic [N-1:0] e_attr;

    gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(W), .MAX_STEPS(MAXS)) dut (
        .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
        .gads_s0(gads_s0), .gads_s1(gads_s1), .reset_nos(reset_nos),
        .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
        .busy(busy), .done(done), .found(found), .timeout(timeout),
        .meet_steps(meet_steps), .period(period), .attractor(attractor)
    );

    always #5 clk = ~clk;

    // network update rule: 0 identity, 1 toggle, 2 rotate-left, 3 binary counter, 4 random table
    function automatic logic [N-1:0] f(input logic [N-1:0] s);
        case (mode)
            0: return s;
            1: return ~s;
            2: return {s[N-2:0], s[N-1]};
            3: return s + 1'b1;
            default: return tab[s];
        endcase
    endfunction

    // nodes: reload on reset_nos, tortoise advances on every second start_s0, hare on every start_s1
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s0 <= '0; s1 <= '0; flag <= 1'b0;
        end else if (reset_nos) begin
            s0 <= init_state; s1 <= init_state; flag <= 1'b1;
        end else begin
            if (start_s0) begin
                if (flag) s0 <= f(s0);
                flag <= ~flag;
            end
            if (start_s1) s1 <= f(s1);
        end
    end
    assign gads_s0 = s0;
    assign gads_s1 = s1;

    // protocol monitor
    always @(negedge clk) begin
        if (!rst) begin
            n_rst  += int'(reset_nos);
            n_s0   += int'(start_s0);
            n_s1   += int'(start_s1);
            n_busy += int'(busy);
            n_done += int'(done);
            if (reset_nos) begin
                vectors++;
                if (prev_rn || start_s0 || start_s1) begin
                    errors++;
                    $display("FAIL reset_nos_pulse got wide=%0b s0=%0b s1=%0b want 0 0 0", prev_rn, start_s0, start_s1);
                end
            end
            if (done) begin
                vectors++;
                if (prev_done || (found && timeout)) begin
                    errors++;
                    $display("FAIL done_pulse got wide=%0b found&timeout=%0b want 0 0", prev_done, found && timeout);
                end
            end
        end
        prev_rn   = reset_nos;
        prev_done = done;
    end

    // orbit-based expectation: x[i] = f^i(x0), tortoise at x[k/2], hare at x[k]
    task automatic model(input logic [N-1:0] x0);
        logic [N-1:0] xs [0:2*MAXS+1];
        xs[0] = x0;
        for (int i = 1; i <= 2 * MAXS + 1; i++) xs[i] = f(xs[i-1]);
        e_found = 0; e_to = 0; e_k = 0; e_p = 0; e_attr = '0;
        for (int k = 1; k <= MAXS; k++) begin
            if (k % 2 == 0 && xs[k/2] == xs[k]) begin
                e_k = k; e_attr = xs[k/2];
                break;
            end
            if (k == MAXS) begin e_k = MAXS; e_to = 1; end
        end
        if (!e_to) begin
            for (int p = 1; p <= MAXS; p++) begin
                e_p = p;
                if (xs[e_k + p] == e_attr) begin e_found = 1; break; end
                if (p == MAXS) e_to = 1;
            end
        end
    endtask

    task automatic run_check(input string name, input int m, input logic [N-1:0] v, input bit spam);
        bit ok = 0;
        int e_meet, e_per;
        mode = m;
        model(v);
        e_meet = (e_found || e_p > 0) ? e_k : 0;
        e_per  = e_found ? e_p : 0;
        @(negedge clk);
        n_rst = 0; n_s0 = 0; n_s1 = 0; n_busy = 0; n_done = 0;
        start = 1; init_vec = v;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
            if (spam) begin
                start = busy ? 1'($urandom_range(1)) : 1'b0;
                init_vec = N'($urandom);
            end
        end
        start = 0;
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL %s done_wait got no done want done within 2000 cycles", name);
            return;
        end
        vectors += 10;
        if (found !== e_found) begin errors++; $display("FAIL %s found got %0b want %0b", name, found, e_found); end
        if (timeout !== e_to) begin errors++; $display("FAIL %s timeout got %0b want %0b", name, timeout, e_to); end
        if (meet_steps !== W'(e_meet)) begin errors++; $display("FAIL %s meet_steps got %0d want %0d", name, meet_steps, e_meet); end
        if (period !== W'(e_per)) begin errors++; $display("FAIL %s period got %0d want %0d", name, period, e_per); end
        if (attractor !== e_attr) begin errors++; $display("FAIL %s attractor got %h want %h", name, attractor, e_attr); end
        if (init_state !== v) begin errors++; $display("FAIL %s init_state got %h want %h", name, init_state, v); end
        if (n_rst != 1) begin errors++; $display("FAIL %s reset_nos_count got %0d want 1", name, n_rst); end
        if (n_s0 != e_k) begin errors++; $display("FAIL %s s0_pulses got %0d want %0d", name, n_s0, e_k); end
        if (n_s1 != e_k + e_p) begin errors++; $display("FAIL %s s1_pulses got %0d want %0d", name, n_s1, e_k + e_p); end
        if (n_busy != 1 + 2 * (e_k + e_p)) begin errors++; $display("FAIL %s busy_cycles got %0d want %0d", name, n_busy, 1 + 2 * (e_k + e_p)); end
        repeat (3) @(negedge clk);
        vectors++;
        if (done || busy || start_s0 || start_s1 || n_done != 1) begin
            errors++;
            $display("FAIL %s after_done got done=%0b busy=%0b s0=%0b s1=%0b dones=%0d want 0 0 0 0 1", name, done, busy, start_s0, start_s1, n_done);
        end
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if ({reset_nos, start_s0, start_s1, busy, done, found, timeout} !== 7'b0 ||
            init_state !== '0 || attractor !== '0 || meet_steps !== '0 || period !== '0) begin
            errors++;
            $display("FAIL %s outputs got %b %h %h %0d %0d want all zero", name,
                     {reset_nos, start_s0, start_s1, busy, done, found, timeout}, init_state, attractor, meet_steps, period);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 0;
    endtask

    task automatic test_fixed_point();
        run_check("identity_a", 0, 8'hA, 0);
        run_check("identity_rand", 0, N'($urandom), 0);
    endtask

    task automatic test_toggle();
        run_check("toggle_0", 1, 8'h00, 0);
        run_check("toggle_rand", 1, N'($urandom), 0);
    endtask

    task automatic test_rotate();
        run_check("rotate_01", 2, 8'h01, 0);
        run_check("rotate_55", 2, 8'h55, 0);
        run_check("rotate_rand", 2, N'($urandom), 0);
    endtask

    task automatic test_timeout();
        run_check("counter_timeout", 3, 8'h00, 0);
    endtask

    task automatic test_random_networks();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 256; i++) tab[i] = N'($urandom);
            run_check("random_net", 4, N'($urandom), 0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 256; i++) tab[i] = N'($urandom);
        run_check("spam_random", 4, N'($urandom), 1);
        run_check("spam_rotate", 2, 8'h81, 1);
        run_check("b2b_rotate", 2, 8'h03, 0);
    endtask

    task automatic test_mid_reset();
        bit hit = 0;
        int dones;
        mode = 2;
        @(negedge clk);
        start = 1; init_vec = 8'h01;
        @(negedge clk);
        start = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (start_s1 && !start_s0) begin hit = 1; break; end
        end
        vectors++;
        if (!hit) begin errors++; $display("FAIL mid_reset p_step_wait got none want P_STEP within 200 cycles"); end
        dones = n_done;
        rst = 1;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if (n_done != dones || done) begin errors++; $display("FAIL mid_reset done_after_rst got %0d want %0d", n_done - dones, 0); end
        run_check("after_rst", 2, 8'h01, 0);
    endtask

    initial begin
        test_reset();
        test_fixed_point();
        test_toggle();
        test_rotate();
        test_timeout();
        test_random_networks();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
